// File: rtl/rv32_bus_pkg.sv
// Shared types and defaults for the RV32 data-side bus router.
// Holds the FSM state encoding, the default four-slave memory map and the index-width helper.
package rv32_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        ERR
    } bus_state_t;

    localparam int DEFAULT_N_SLAVES = 4;
    localparam int ERR_COUNT_W      = 16;

    // Entry 0 sits in the least significant 32 bits.
    localparam logic [DEFAULT_N_SLAVES*32-1:0] DEFAULT_SLAVE_BASE = {
        32'h2002_0000, 32'h2001_0000, 32'h2000_0000, 32'h1000_0000
    };
    localparam logic [DEFAULT_N_SLAVES*32-1:0] DEFAULT_SLAVE_MASK = {
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FFE0, 32'hF000_0000
    };

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv32_addr_decoder.sv
// Combinational address decoder: matches an address against per-slave base/mask windows.
// The lowest matching index wins, and the one-hot output marks only that winner.
module rv32_addr_decoder
    import rv32_bus_pkg::*;
#(
    parameter int N_SLAVES = DEFAULT_N_SLAVES,
    parameter int ADDR_W   = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEFAULT_SLAVE_BASE,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = DEFAULT_SLAVE_MASK,
    localparam int IDX_W = idx_w(N_SLAVES)
) (
    input  logic [ADDR_W-1:0]   addr_i,
    output logic                hit_o,
    output logic [IDX_W-1:0]    idx_o,
    output logic [N_SLAVES-1:0] match_o
);

    logic [N_SLAVES-1:0] raw_match;

    // NOTE: every output gets a default before the loops, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        raw_match = '0;
        hit_o     = 1'b0;
        idx_o     = '0;
        match_o   = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            raw_match[k] = ((addr_i & SLAVE_MASK[k*ADDR_W +: ADDR_W])
                            == SLAVE_BASE[k*ADDR_W +: ADDR_W]);
        end
        // Walk downwards so the lowest matching index is written last.
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if (raw_match[k]) begin
                hit_o   = 1'b1;
                idx_o   = IDX_W'(k);
                match_o = N_SLAVES'(1) << k;
            end
        end
    end

endmodule

// File: rtl/rv32_data_bus_router.sv
// Data-side bus router: forwards one core access at a time to a decoded slave and stalls until it acks.
// Unmapped or timed-out accesses finish with err_o and bump a saturating error counter.
module rv32_data_bus_router
    import rv32_bus_pkg::*;
#(
    parameter int N_SLAVES = DEFAULT_N_SLAVES,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 255,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEFAULT_SLAVE_BASE,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = DEFAULT_SLAVE_MASK
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_i,
    input  logic [DATA_W/8-1:0]          we_i,
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    output logic [DATA_W-1:0]            rdata_o,
    output logic                         ack_o,
    output logic                         err_o,
    output logic                         stall_o,
    output logic [ERR_COUNT_W-1:0]       err_count_o,
    output logic [N_SLAVES-1:0]          s_sel_o,
    output logic [DATA_W/8-1:0]          s_we_o,
    output logic [ADDR_W-1:0]            s_addr_o,
    output logic [DATA_W-1:0]            s_wdata_o,
    input  logic [N_SLAVES*DATA_W-1:0]   s_rdata_i,
    input  logic [N_SLAVES-1:0]          s_ack_i
);

    localparam int IDX_W = idx_w(N_SLAVES);
    localparam int BE_W  = DATA_W / 8;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    bus_state_t             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [N_SLAVES-1:0]    sel_q, sel_d;
    logic [BE_W-1:0]        we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic [ERR_COUNT_W-1:0] err_count_q, err_count_d;

    logic                   dec_hit;
    logic [IDX_W-1:0]       dec_idx;
    logic [N_SLAVES-1:0]    dec_onehot;
    logic                   sel_ack;
    logic [DATA_W-1:0]      sel_rdata;
    logic                   go_err;

    rv32_addr_decoder #(
        .N_SLAVES   (N_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decoder (
        .addr_i  (addr_i),
        .hit_o   (dec_hit),
        .idx_o   (dec_idx),
        .match_o (dec_onehot)
    );

    // Only the latched target's ack and data are ever looked at.
    assign sel_ack   = s_ack_i[idx_q];
    assign sel_rdata = s_rdata_i[idx_q*DATA_W +: DATA_W];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        sel_d       = sel_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        go_err      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (dec_hit) begin
                        state_d = BUSY;
                        idx_d   = dec_idx;
                        sel_d   = dec_onehot;
                        we_d    = we_i;
                        addr_d  = addr_i;
                        wdata_d = wdata_i;
                        timer_d = '0;
                    end else begin
                        go_err = 1'b1;
                    end
                end
            end
            BUSY: begin
                // An ack in the final cycle still wins over the timeout.
                if (sel_ack) begin
                    state_d = DONE;
                    sel_d   = '0;
                    rdata_d = sel_rdata;
                    ack_d   = 1'b1;
                end else if (timer_q == TMR_LAST) begin
                    sel_d  = '0;
                    go_err = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (go_err) begin
            state_d     = ERR;
            err_d       = 1'b1;
            rdata_d     = '0;
            err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            timer_q     <= '0;
            sel_q       <= '0;
            we_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign stall_o     = ((state_q == IDLE) && req_i) || (state_q == BUSY);
    assign rdata_o     = rdata_q;
    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign err_count_o = err_count_q;
    assign s_sel_o     = sel_q;
    assign s_we_o      = we_q;
    assign s_addr_o    = addr_q;
    assign s_wdata_o   = wdata_q;

endmodule

// File: tb/tb_rv32_data_bus_router.sv
// Self-checking bench for rv32_data_bus_router: directed cases plus random transactions
// checked cycle by cycle against a transaction-level model of the memory map and timing.
module tb_rv32_data_bus_router;

    localparam int NS      = 4;
    localparam int TIMEOUT = 8;

    logic              clk;
    logic              rst;
    logic              req_i;
    logic [3:0]        we_i;
    logic [31:0]       addr_i;
    logic [31:0]       wdata_i;
    logic [31:0]       rdata_o;
    logic              ack_o;
    logic              err_o;
    logic              stall_o;
    logic [15:0]       err_count_o;
    logic [NS-1:0]     s_sel_o;
    logic [3:0]        s_we_o;
    logic [31:0]       s_addr_o;
    logic [31:0]       s_wdata_o;
    logic [NS*32-1:0]  s_rdata_i;
    logic [NS-1:0]     s_ack_i;

    logic              req2;
    logic [31:0]       addr2;
    logic [NS-1:0]     s_ack2;
    logic [31:0]       rdata2;
    logic              ack2;
    logic              err2;
    logic              stall2;
    logic [15:0]       err_count2;
    logic [NS-1:0]     s_sel2;
    logic [3:0]        s_we2;
    logic [31:0]       s_addr2;
    logic [31:0]       s_wdata2;

    int checks = 0;
    int errors = 0;

    logic [31:0] base_t [NS] = '{32'h1000_0000, 32'h2000_0000, 32'h2001_0000, 32'h2002_0000};
    logic [31:0] mask_t [NS] = '{32'hF000_0000, 32'hFFFF_FFE0, 32'hFFFF_0000, 32'hFFFF_0000};

    logic [31:0] m_rdata;
    logic [15:0] m_cnt;
    logic [3:0]  m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;

    rv32_data_bus_router #(
        .N_SLAVES (NS),
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT  (TIMEOUT)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .ack_o       (ack_o),
        .err_o       (err_o),
        .stall_o     (stall_o),
        .err_count_o (err_count_o),
        .s_sel_o     (s_sel_o),
        .s_we_o      (s_we_o),
        .s_addr_o    (s_addr_o),
        .s_wdata_o   (s_wdata_o),
        .s_rdata_i   (s_rdata_i),
        .s_ack_i     (s_ack_i)
    );

    // Second instance whose slave 1 window sits on top of slave 0.
    rv32_data_bus_router #(
        .N_SLAVES   (NS),
        .ADDR_W     (32),
        .DATA_W     (32),
        .TIMEOUT    (TIMEOUT),
        .SLAVE_BASE ({32'h2002_0000, 32'h2001_0000, 32'h1000_0000, 32'h1000_0000}),
        .SLAVE_MASK ({32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FFE0, 32'hF000_0000})
    ) u_ovl (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req2),
        .we_i        (we_i),
        .addr_i      (addr2),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata2),
        .ack_o       (ack2),
        .err_o       (err2),
        .stall_o     (stall2),
        .err_count_o (err_count2),
        .s_sel_o     (s_sel2),
        .s_we_o      (s_we2),
        .s_addr_o    (s_addr2),
        .s_wdata_o   (s_wdata2),
        .s_rdata_i   (s_rdata_i),
        .s_ack_i     (s_ack2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_decode(input logic [31:0] a);
        for (int k = 0; k < NS; k++) begin
            if ((a & mask_t[k]) == base_t[k]) return k;
        end
        return -1;
    endfunction

    task automatic check_quiet_regs(input string tag);
        check({tag, ".rdata"}, rdata_o, m_rdata);
        check({tag, ".cnt"}, err_count_o, m_cnt);
        check({tag, ".s_addr"}, s_addr_o, m_addr);
        check({tag, ".s_we"}, s_we_o, m_we);
        check({tag, ".s_wdata"}, s_wdata_o, m_wdata);
    endtask

    // One full access, starting at a negedge in IDLE and ending at the negedge of the next IDLE cycle.
    // dly = BUSY cycles before the slave acks (0 = first BUSY cycle); dly >= TIMEOUT means never.
    task automatic run_txn(input string tag, input logic [31:0] a, input logic [3:0] we,
                           input logic [31:0] wd, input int dly, input logic [31:0] rd,
                           input bit noise);
        int idx;
        int resp;
        bit is_ack;
        logic [3:0] exp_sel;
        idx = model_decode(a);
        if (idx < 0) begin
            resp = 1;  is_ack = 1'b0;
        end else if (dly < TIMEOUT) begin
            resp = dly + 2;  is_ack = 1'b1;
        end else begin
            resp = TIMEOUT + 1;  is_ack = 1'b0;
        end
        for (int c = 0; c <= resp; c++) begin
            if (c < resp) begin
                req_i = 1'b1;  addr_i = a;  we_i = we;  wdata_i = wd;
            end else begin
                req_i = 1'b0;  addr_i = $urandom;  we_i = 4'($urandom);  wdata_i = $urandom;
            end
            s_ack_i = '0;
            if (idx >= 0 && c >= 1 && c < resp) begin
                if (c - 1 == dly) s_ack_i[idx] = 1'b1;
                if (noise) s_ack_i[(idx + 1) % NS] = 1'b1;
            end
            for (int k = 0; k < NS; k++) s_rdata_i[k*32 +: 32] = (k == idx) ? rd : $urandom;
            if (c == 1 && idx >= 0) begin
                m_we = we;  m_addr = a;  m_wdata = wd;
            end
            if (c == resp) begin
                if (is_ack) m_rdata = rd;
                else begin
                    m_rdata = '0;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
            end
            exp_sel = (idx >= 0 && c >= 1 && c < resp) ? (4'b0001 << idx) : 4'b0000;
            #1;
            check({tag, ".stall"}, stall_o, (c < resp));
            check({tag, ".sel"}, s_sel_o, exp_sel);
            check({tag, ".ack"}, ack_o, (is_ack && c == resp));
            check({tag, ".err"}, err_o, (!is_ack && c == resp));
            check_quiet_regs(tag);
            @(negedge clk);
        end
    endtask

    initial begin
        int sel;
        logic [31:0] a;

        rst = 1'b1;  req_i = 1'b0;  we_i = '0;  addr_i = '0;  wdata_i = '0;
        s_rdata_i = '0;  s_ack_i = '0;
        req2 = 1'b0;  addr2 = '0;  s_ack2 = '0;
        m_rdata = '0;  m_cnt = '0;  m_we = '0;  m_addr = '0;  m_wdata = '0;

        repeat (2) @(negedge clk);
        check("reset.sel", s_sel_o, 4'b0000);
        check("reset.ack", ack_o, 1'b0);
        check("reset.err", err_o, 1'b0);
        check("reset.stall", stall_o, 1'b0);
        check_quiet_regs("reset");
        rst = 1'b0;
        @(negedge clk);

        run_txn("rd_slave0",  32'h1000_0040, 4'b0000, 32'h0,          0,   32'hDEAD_BEEF, 1'b0);
        run_txn("wr_uart",    32'h2000_0004, 4'b0011, 32'h1234_5678, 2,   32'h0000_00AA, 1'b0);
        run_txn("unmapped",   32'h3000_0000, 4'b0000, 32'h0,          0,   32'h0,         1'b0);
        run_txn("spi_tmo",    32'h2001_0000, 4'b0000, 32'h0,          100, 32'h5555_AAAA, 1'b0);
        run_txn("spi_late",   32'h2001_0000, 4'b1111, 32'hCAFE_F00D, TIMEOUT - 1, 32'h0BAD_CAFE, 1'b0);
        run_txn("uart_noise", 32'h2000_0008, 4'b0000, 32'h0,          3,   32'h7777_1111, 1'b1);
        run_txn("slave3",     32'h2002_0ABC, 4'b0100, 32'h00C0_0000, 1,   32'h3333_3333, 1'b1);

        // Reset in the middle of a BUSY access.
        req_i = 1'b1;  addr_i = 32'h2001_0010;  we_i = 4'b0000;  s_ack_i = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid.sel_before", s_sel_o, 4'b0100);
        rst = 1'b1;  req_i = 1'b0;
        m_rdata = '0;  m_cnt = '0;  m_we = '0;  m_addr = '0;  m_wdata = '0;
        #1;
        check("rst_mid.sel", s_sel_o, 4'b0000);
        check("rst_mid.stall", stall_o, 1'b0);
        check_quiet_regs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            s_ack_i = 4'b0100;
            @(negedge clk);
            check("rst_mid.ack_after", ack_o, 1'b0);
            check("rst_mid.err_after", err_o, 1'b0);
            check("rst_mid.sel_after", s_sel_o, 4'b0000);
        end
        s_ack_i = '0;

        // Overlapping windows: slave 0 must win.
        s_rdata_i = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        req2 = 1'b1;  addr2 = 32'h1000_0004;
        #1;
        check("ovl.stall", stall2, 1'b1);
        @(negedge clk);
        req2 = 1'b0;  s_ack2 = 4'b0001;
        check("ovl.sel", s_sel2, 4'b0001);
        @(negedge clk);
        s_ack2 = '0;
        check("ovl.ack", ack2, 1'b1);
        check("ovl.rdata", rdata2, 32'h1111_1111);
        @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, NS);
            if (sel < NS) a = (base_t[sel] & mask_t[sel]) | ($urandom & ~mask_t[sel]);
            else          a = $urandom;
            run_txn("rand", a, 4'($urandom), $urandom, $urandom_range(0, 10), $urandom,
                    1'($urandom_range(0, 1)));
        end

        // Preload the counter near its ceiling, then push errors past it.
        force u_dut.err_count_q = 16'hFFFD;
        @(negedge clk);
        release u_dut.err_count_q;
        m_cnt = 16'hFFFD;
        for (int t = 0; t < 4; t++) run_txn("sat", 32'h4000_0000, 4'b0000, 32'h0, 0, 32'h0, 1'b0);
        check("sat.final", err_count_o, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
